// File: rtl/srl_stream_ctrl.sv
// Valid/ready front-end for a 32-deep SRL delay line used as a fixed-latency FIFO.
// Shadows per-entry validity (SRL contents have no reset) and supports bubble-free flush.
module srl_stream_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 32,
  parameter int CW         = 6,
  localparam int W         = DATA_WIDTH * 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [W-1:0]  s_data,
  input  logic          flush,
  output logic          srl_ce,
  output logic [W-1:0]  srl_din,
  input  logic [W-1:0]  srl_dout,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [W-1:0]  m_data,
  output logic [CW-1:0] fill_cnt,
  output logic          busy
);

  typedef enum logic [1:0] {FILL, RUN, DRAIN} state_t;

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_t           state;
  logic [DEPTH-1:0] vld_sr;
  logic             out_free;
  logic             top_vld;
  logic             xfer;
  logic             pop_real;
  logic [CW-1:0]    cnt_after_xfer;

  always_comb begin
    out_free = !m_valid | m_ready;
    top_vld  = vld_sr[DEPTH-1];
    s_ready  = 1'b0;
    srl_ce   = 1'b0;
    srl_din  = s_data;
    case (state)
      FILL: begin
        s_ready = 1'b1;
        srl_ce  = s_valid;
      end
      RUN: begin
        s_ready = out_free;
        srl_ce  = s_valid & out_free;
      end
      DRAIN: begin
        // Bubbles at the tap shift freely; a real sample waits for the output slot.
        srl_din = '0;
        srl_ce  = !top_vld | out_free;
      end
      default: ;
    endcase
    xfer           = s_valid & s_ready;
    pop_real       = srl_ce & top_vld;
    cnt_after_xfer = fill_cnt + CW'(xfer);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FILL;
      fill_cnt <= '0;
      vld_sr   <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      busy     <= 1'b0;
    end else begin
      if (srl_ce) vld_sr <= {vld_sr[DEPTH-2:0], xfer};

      if (pop_real) begin
        m_data  <= srl_dout;
        m_valid <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end

      case (state)
        FILL: begin
          fill_cnt <= cnt_after_xfer;
          if (flush) begin
            if (cnt_after_xfer != '0) begin
              state <= DRAIN;
              busy  <= 1'b1;
            end
          end else if (cnt_after_xfer == FULL) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (flush) begin
            state <= DRAIN;
            busy  <= 1'b1;
          end
        end
        DRAIN: begin
          if (pop_real) begin
            fill_cnt <= fill_cnt - CW'(1);
            if (fill_cnt == CW'(1)) begin
              state <= FILL;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= FILL;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  fill_cnt_range: assert property (@(posedge clk) disable iff (rst) fill_cnt <= FULL);

endmodule

// File: tb/tb_srl_stream_ctrl.sv
// Bench for srl_stream_ctrl: behavioural SRL, slot-queue reference model with
// per-cycle comparison, an in-order scoreboard and directed literal checks.
module tb_srl_stream_ctrl;
  localparam int DW    = 16;
  localparam int W     = 2 * DW;
  localparam int DEPTH = 32;
  localparam int CW    = 6;

  localparam int M_FILL  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W-1:0]  s_data = '0;
  logic          flush = 1'b0;
  logic          srl_ce;
  logic [W-1:0]  srl_din;
  logic [W-1:0]  srl_dout;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [W-1:0]  m_data;
  logic [CW-1:0] fill_cnt;
  logic          busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  srl_stream_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .flush(flush), .srl_ce(srl_ce), .srl_din(srl_din), .srl_dout(srl_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .fill_cnt(fill_cnt),
    .busy(busy)
  );

  // Delay line: tap at depth 32, contents start as garbage and are never reset.
  logic [W-1:0] srl_mem [DEPTH];
  bit           srl_primed = 1'b0;
  assign srl_dout = srl_mem[DEPTH-1];

  always @(posedge clk) begin
    if (!srl_primed) begin
      for (int k = 0; k < DEPTH; k++) srl_mem[k] <= 32'hDEAD_0000 | W'(k);
      srl_primed <= 1'b1;
    end else if (srl_ce) begin
      for (int k = DEPTH - 1; k > 0; k--) srl_mem[k] <= srl_mem[k-1];
      srl_mem[0] <= srl_din;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the line is a queue of 32 slots, newest at index 0.
  typedef struct packed {
    logic         tag;
    logic [W-1:0] d;
  } slot_t;

  slot_t        line_q[$];
  int           mode = M_FILL;
  logic         mv = 1'b0;
  logic [W-1:0] md = '0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  bit           armed = 1'b0;

  function automatic int n_real();
    int n = 0;
    foreach (line_q[k]) if (line_q[k].tag) n++;
    return n;
  endfunction

  always @(negedge clk) begin
    logic         free, rdy, ce, acc;
    logic [W-1:0] din;
    logic [63:0]  e;
    slot_t        top;
    int           n;
    if (armed) begin
      free = !mv || m_ready;
      top  = line_q[DEPTH-1];
      din  = s_data;
      case (mode)
        M_FILL:  begin rdy = 1'b1; ce = s_valid; end
        M_RUN:   begin rdy = free; ce = s_valid && free; end
        default: begin rdy = 1'b0; ce = !top.tag || free; din = '0; end
      endcase
      acc = s_valid && rdy;

      chk("s_ready",  64'(s_ready),  64'(rdy));
      chk("srl_ce",   64'(srl_ce),   64'(ce));
      chk("srl_din",  64'(srl_din),  64'(din));
      chk("m_valid",  64'(m_valid),  64'(mv));
      chk("m_data",   64'(m_data),   64'(md));
      chk("fill_cnt", 64'(fill_cnt), 64'(n_real()));
      chk("busy",     64'(busy),     64'(mode == M_DRAIN));

      if (!rst) begin
        if (m_valid && m_ready) begin
          if (exp_q.size() > 0) e = 64'(exp_q.pop_front());
          else e = '1;
          chk("sb_order", 64'(m_data), e);
          got_q.push_back(m_data);
        end
        if (acc) exp_q.push_back(s_data);

        if (ce) begin
          void'(line_q.pop_back());
          line_q.push_front({acc, din});
        end
        if (ce && top.tag) begin
          mv = 1'b1;
          md = top.d;
        end else if (m_ready) begin
          mv = 1'b0;
        end
        n = n_real();
        case (mode)
          M_FILL: begin
            if (flush) mode = (n > 0) ? M_DRAIN : M_FILL;
            else if (n == DEPTH) mode = M_RUN;
          end
          M_RUN: if (flush) mode = M_DRAIN;
          default: if (n == 0) mode = M_FILL;
        endcase
      end
    end
    if (rst) begin
      line_q.delete();
      for (int k = 0; k < DEPTH; k++) line_q.push_back('0);
      mode  = M_FILL;
      mv    = 1'b0;
      md    = '0;
      exp_q.delete();
      armed = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int maxc);
    int c = 0;
    @(negedge clk);
    while (busy && c < maxc) begin
      @(negedge clk);
      c++;
    end
    chk("drain_done", 64'(busy), 64'(0));
  endtask

  task automatic chk_got(input string name, input logic [W-1:0] first, input int cnt);
    chk({name, "_count"}, 64'(got_q.size()), 64'(cnt));
    for (int k = 0; k < got_q.size() && k < cnt; k++)
      chk(name, 64'(got_q[k]), 64'(first + W'(k)));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_m_valid",  64'(m_valid),  64'(0));
    chk("rst_m_data",   64'(m_data),   64'(0));
    chk("rst_fill_cnt", 64'(fill_cnt), 64'(0));
    chk("rst_busy",     64'(busy),     64'(0));
    chk("rst_s_ready",  64'(s_ready),  64'(1));
    chk("rst_srl_ce",   64'(srl_ce),   64'(0));

    // Fill with 1..32, then stream 33..40: outputs 1..8 back-to-back.
    for (int i = 1; i <= 40; i++) begin
      tick();
      s_valid = 1'b1;
      s_data  = W'(i);
      @(negedge clk);
      if (i <= 33) begin
        chk("fill_no_valid", 64'(m_valid), 64'(0));
        chk("fill_s_ready",  64'(s_ready), 64'(1));
      end else begin
        chk("lat_valid", 64'(m_valid), 64'(1));
        chk("lat_data",  64'(m_data),  64'(i - 33));
      end
      if (i == 33) chk("fill_full", 64'(fill_cnt), 64'(32));
    end
    tick();
    s_valid = 1'b0;
    @(negedge clk);
    chk("lat_last", 64'(m_data), 64'(8));
    tick();
    @(negedge clk);
    chk("idle_run_drop", 64'(m_valid), 64'(0));

    // Backpressure for 5 cycles with input pending.
    tick();
    got_q.delete();
    s_valid = 1'b1;
    s_data  = W'(41);
    tick();
    m_ready = 1'b0;
    s_data  = W'(42);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_m_valid", 64'(m_valid), 64'(1));
      chk("bp_m_data",  64'(m_data),  64'(9));
      chk("bp_s_ready", 64'(s_ready), 64'(0));
      chk("bp_srl_ce",  64'(srl_ce),  64'(0));
      tick();
    end
    m_ready = 1'b1;
    for (int j = 42; j <= 49; j++) begin
      s_data = W'(j);
      tick();
    end
    s_valid = 1'b0;
    flush   = 1'b1;
    tick();
    flush = 1'b0;
    wait_idle(100);
    tick();
    tick();
    chk_got("bp_seq", W'(9), 41);
    chk("bp_end_fill", 64'(fill_cnt), 64'(0));

    // Partial fill of 5 then flush.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got_q.delete();
    for (int v = 'hA1; v <= 'hA5; v++) begin
      s_valid = 1'b1;
      s_data  = W'(v);
      tick();
    end
    s_valid = 1'b0;
    flush   = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("fl_busy",     64'(busy),     64'(1));
    chk("fl_srl_din",  64'(srl_din),  64'(0));
    chk("fl_s_ready",  64'(s_ready),  64'(0));
    chk("fl_fill_cnt", 64'(fill_cnt), 64'(5));
    wait_idle(64);
    tick();
    tick();
    chk_got("fl_seq", W'('hA1), 5);
    chk("fl_end_fill", 64'(fill_cnt), 64'(0));
    chk("fl_end_busy", 64'(busy),     64'(0));

    // Flush coinciding with the only transfer, fill_cnt was 0.
    got_q.delete();
    s_valid = 1'b1;
    s_data  = W'('hB7);
    flush   = 1'b1;
    tick();
    s_valid = 1'b0;
    flush   = 1'b0;
    @(negedge clk);
    chk("fx_busy", 64'(busy),     64'(1));
    chk("fx_fill", 64'(fill_cnt), 64'(1));
    wait_idle(64);
    tick();
    tick();
    chk_got("fx_seq", W'('hB7), 1);
    chk("fx_end_fill", 64'(fill_cnt), 64'(0));

    // Reset mid-RUN with an output stalled, then refill.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_ready = 1'b0;
    for (int i = 1; i <= 34; i++) begin
      s_valid = 1'b1;
      s_data  = W'('h100 + i);
      tick();
    end
    s_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", 64'(m_valid), 64'(1));
    chk("pre_rst_data",  64'(m_data),  64'('h101));
    tick();
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 64'(m_valid),  64'(0));
    chk("post_rst_fill",  64'(fill_cnt), 64'(0));
    for (int i = 1; i <= 33; i++) begin
      tick();
      s_valid = 1'b1;
      s_data  = W'('h200 + i);
      @(negedge clk);
      chk("no_stale", 64'(m_valid), 64'(0));
    end
    tick();
    s_valid = 1'b0;
    @(negedge clk);
    chk("first_new_valid", 64'(m_valid), 64'(1));
    chk("first_new_data",  64'(m_data),  64'('h201));

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
